// File: rtl/afpm_pkg.sv
// Shared constants and helpers for the approximate FP multiplier front end.
package afpm_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned DEF_OP_W = 16;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    function automatic int unsigned nbytes(input int unsigned op_w);
        return op_w / BYTE_W;
    endfunction

endpackage

// File: rtl/afpm_idle_timer.sv
// Idle counter that flags a stalled partial frame; instantiated only when
// AFPM_FRAME_TIMEOUT_EN is defined.
module afpm_idle_timer
    import afpm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic busy_i,
    input  logic beat_i,
    output logic expire_o
);

    localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);

    logic [IW-1:0] idle_q, idle_d;

    always_comb begin
        expire_o = 1'b0;
        idle_d   = idle_q;
        if (clr_i || beat_i || !busy_i) begin
            idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
            // Last idle cycle: fire now so the frame is gone after TIMEOUT_CYC edges.
            expire_o = 1'b1;
            idle_d   = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/afpm_operand_loader.sv
// Byte-serial to parallel operand loader with a double-buffered output stage.
// Optional partial-frame timeout enabled by AFPM_FRAME_TIMEOUT_EN.
module afpm_operand_loader
    import afpm_pkg::*;
#(
    parameter int unsigned OP_W        = DEF_OP_W,
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sync_clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_a,
    input  logic [7:0]      in_b,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic            busy,
    output logic            frame_drop
);

    localparam int unsigned NB = nbytes(OP_W);
    localparam int unsigned CW = $clog2(NB);

    if ((OP_W % BYTE_W) != 0 || OP_W < 16 || TIMEOUT_CYC == 0) begin : g_bad_params
        $error("afpm_operand_loader: illegal OP_W or TIMEOUT_CYC");
    end

    logic [CW-1:0]   count_q, count_d;
    logic [OP_W-1:0] asm_a_q, asm_a_d, asm_b_q, asm_b_d;
    logic [OP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [OP_W-1:0] asm_a_nxt, asm_b_nxt;
    logic            op_valid_q, op_valid_d;
    logic            frame_drop_q, frame_drop_d;
    logic            last_beat, accept, complete, expire;

    assign last_beat = (count_q == CW'(NB - 1));
    assign in_ready  = !(last_beat && op_valid_q && !op_ready);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && last_beat && !sync_clr;
    assign busy      = (count_q != '0);

`ifdef AFPM_FRAME_TIMEOUT_EN
    afpm_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (sync_clr),
        .busy_i   (busy),
        .beat_i   (accept),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        asm_a_nxt = asm_a_q;
        asm_b_nxt = asm_b_q;
        asm_a_nxt[{count_q, 3'b000} +: BYTE_W] = in_a;
        asm_b_nxt[{count_q, 3'b000} +: BYTE_W] = in_b;

        count_d      = count_q;
        asm_a_d      = asm_a_q;
        asm_b_d      = asm_b_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_valid_d   = op_valid_q;
        frame_drop_d = expire;

        if (op_valid_q && op_ready) begin
            op_valid_d = 1'b0;
        end

        if (sync_clr || expire) begin
            count_d = '0;
        end else if (accept) begin
            asm_a_d = asm_a_nxt;
            asm_b_d = asm_b_nxt;
            count_d = last_beat ? '0 : count_q + 1'b1;
        end

        // A completing frame overrides consumption so back-to-back frames have no bubble.
        if (complete) begin
            op_a_d     = asm_a_nxt;
            op_b_d     = asm_b_nxt;
            op_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            asm_a_q      <= '0;
            asm_b_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_valid_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            asm_a_q      <= asm_a_d;
            asm_b_q      <= asm_b_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_valid_q   <= op_valid_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_valid   = op_valid_q;
    assign frame_drop = frame_drop_q;

endmodule
